// File: rtl/elastic_pipe_chain.sv
// Chain of STAGES valid/ready elastic registers with bubble collapsing, flush,
// freeze, an optional input skid entry and a registered occupancy count.
module elastic_pipe_chain #(
   parameter int WIDTH             = 32,
   parameter int STAGES            = 2,
   parameter int SKID              = 0,
   parameter int FLUSH_CLEARS_DATA = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [WIDTH-1:0]                in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [WIDTH-1:0]                out_data,
   input  logic                            flush,
   input  logic                            freeze,
   output logic [$clog2(STAGES+2)-1:0]     count
);

   localparam int CW = $clog2(STAGES + 2);

   logic [STAGES-1:0] v_q, v_d;
   logic [WIDTH-1:0]  d_q [STAGES];
   logic [WIDTH-1:0]  d_d [STAGES];
   logic [STAGES-1:0] accept;
   logic [CW-1:0]     count_q, count_d;
   logic              run;
   logic              in_fire;
   logic              src_valid;
   logic [WIDTH-1:0]  src_data;
   logic              skid_cnt;

   assign run     = !freeze && !flush;
   assign in_fire = in_valid && in_ready;

   // A stage accepts if it is empty or everything downstream of it moves.
   always_comb begin
      accept = '0;
      accept[STAGES-1] = !v_q[STAGES-1] || (out_ready && run);
      for (int k = STAGES - 2; k >= 0; k--) begin
         accept[k] = !v_q[k] || accept[k+1];
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         logic             skid_valid_q, skid_valid_d;
         logic [WIDTH-1:0] skid_data_q, skid_data_d;

         assign in_ready  = !skid_valid_q && run;
         assign src_valid = skid_valid_q || in_fire;
         assign src_data  = skid_valid_q ? skid_data_q : in_data;
         assign skid_cnt  = skid_valid_d;

         always_comb begin
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            if (flush) begin
               skid_valid_d = 1'b0;
               if (FLUSH_CLEARS_DATA != 0) begin
                  skid_data_d = '0;
               end
            end else if (!freeze) begin
               if (skid_valid_q) begin
                  if (accept[0]) begin
                     skid_valid_d = 1'b0;
                  end
               end else if (in_fire && !accept[0]) begin
                  skid_valid_d = 1'b1;
                  skid_data_d  = in_data;
               end
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               skid_valid_q <= 1'b0;
               skid_data_q  <= '0;
            end else begin
               skid_valid_q <= skid_valid_d;
               skid_data_q  <= skid_data_d;
            end
         end
      end else begin : g_noskid
         assign in_ready  = accept[0] && run;
         assign src_valid = in_fire;
         assign src_data  = in_data;
         assign skid_cnt  = 1'b0;
      end
   endgenerate

   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (flush) begin
         v_d = '0;
         if (FLUSH_CLEARS_DATA != 0) begin
            for (int k = 0; k < STAGES; k++) begin
               d_d[k] = '0;
            end
         end
      end else if (!freeze) begin
         if (accept[0]) begin
            v_d[0] = src_valid;
            if (src_valid) begin
               d_d[0] = src_data;
            end
         end
         for (int k = 1; k < STAGES; k++) begin
            if (accept[k]) begin
               v_d[k] = v_q[k-1];
               if (v_q[k-1]) begin
                  d_d[k] = d_q[k-1];
               end
            end
         end
      end

      // Count reflects the state after this edge, so it tracks the entries exactly.
      count_d = CW'(skid_cnt);
      for (int k = 0; k < STAGES; k++) begin
         count_d = count_d + CW'(v_d[k]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q     <= '0;
         count_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            d_q[k] <= '0;
         end
      end else begin
         v_q     <= v_d;
         count_q <= count_d;
         for (int k = 0; k < STAGES; k++) begin
            d_q[k] <= d_d[k];
         end
      end
   end

   assign out_valid = v_q[STAGES-1] && run;
   assign out_data  = d_q[STAGES-1];
   assign count     = count_q;

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Drives four differently configured chains with shared stimulus and checks each
// against a queue model where every word carries its position in the chain.
module tb_elastic_pipe_chain;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;
   logic        flush;
   logic        freeze;

   logic [3:0]  in_ready_w;
   logic [3:0]  out_valid_w;
   logic [31:0] out_data_w [4];
   logic [1:0]  cnt0;
   logic [2:0]  cnt1;
   logic [2:0]  cnt2;
   logic [1:0]  cnt3;

   int n_assert = 0;
   int n_fail   = 0;

   int          s_of    [4];
   int          skid_of [4];
   int          fcd_of  [4];
   logic [31:0] m_data  [4][12];
   int          m_pos   [4][12];
   int          m_size  [4];

   always #5 clk = ~clk;

   elastic_pipe_chain #(.WIDTH(32), .STAGES(2), .SKID(0), .FLUSH_CLEARS_DATA(1)) u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_data(in_data),
      .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]),
      .flush(flush), .freeze(freeze), .count(cnt0));

   elastic_pipe_chain #(.WIDTH(32), .STAGES(3), .SKID(0), .FLUSH_CLEARS_DATA(1)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_data(in_data),
      .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]),
      .flush(flush), .freeze(freeze), .count(cnt1));

   elastic_pipe_chain #(.WIDTH(32), .STAGES(3), .SKID(1), .FLUSH_CLEARS_DATA(0)) u_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]), .in_data(in_data),
      .out_valid(out_valid_w[2]), .out_ready(out_ready), .out_data(out_data_w[2]),
      .flush(flush), .freeze(freeze), .count(cnt2));

   elastic_pipe_chain #(.WIDTH(32), .STAGES(1), .SKID(1), .FLUSH_CLEARS_DATA(1)) u_d (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[3]), .in_data(in_data),
      .out_valid(out_valid_w[3]), .out_ready(out_ready), .out_data(out_data_w[3]),
      .flush(flush), .freeze(freeze), .count(cnt3));

   function automatic int get_count(input int d);
      case (d)
         0:       return int'(cnt0);
         1:       return int'(cnt1);
         2:       return int'(cnt2);
         default: return int'(cnt3);
      endcase
   endfunction

   function automatic bit m_run();
      return !flush && !freeze;
   endfunction

   // The oldest word is presented once it has reached the last stage.
   function automatic bit m_out_valid(input int d);
      return m_run() && m_size[d] > 0 && m_pos[d][0] == s_of[d];
   endfunction

   function automatic bit m_in_ready(input int d);
      if (!m_run()) return 1'b0;
      if (skid_of[d] != 0) return !(m_size[d] > 0 && m_pos[d][m_size[d]-1] == 0);
      return m_size[d] < s_of[d] || (m_out_valid(d) && out_ready);
   endfunction

   // Position 0 means waiting in the skid entry; word i can sit no further
   // forward than S-i because the i older words occupy the stages ahead of it.
   task automatic model_step(input int d);
      bit ov;
      bit ir;
      ov = m_out_valid(d);
      ir = m_in_ready(d);
      if (flush) begin
         m_size[d] = 0;
      end else if (!freeze) begin
         if (ov && out_ready) begin
            for (int i = 0; i < m_size[d] - 1; i++) begin
               m_data[d][i] = m_data[d][i+1];
               m_pos[d][i]  = m_pos[d][i+1];
            end
            m_size[d]--;
         end
         if (in_valid && ir) begin
            m_data[d][m_size[d]] = in_data;
            m_pos[d][m_size[d]]  = 0;
            m_size[d]++;
         end
         for (int i = 0; i < m_size[d]; i++) begin
            m_pos[d][i] = (m_pos[d][i] + 1 < s_of[d] - i) ? m_pos[d][i] + 1 : s_of[d] - i;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      for (int d = 0; d < 4; d++) begin
         check($sformatf("dut%0d in_ready", d), 32'(in_ready_w[d]), 32'(m_in_ready(d)));
         check($sformatf("dut%0d out_valid", d), 32'(out_valid_w[d]), 32'(m_out_valid(d)));
         check($sformatf("dut%0d count", d), 32'(get_count(d)), 32'(m_size[d]));
         if (m_out_valid(d)) begin
            check($sformatf("dut%0d out_data", d), out_data_w[d], m_data[d][0]);
         end
      end
   endtask

   // Inputs are set just after a rising edge; outputs are checked on the falling edge.
   task automatic cycle();
      @(negedge clk);
      check_outputs();
      for (int d = 0; d < 4; d++) begin
         if (rst) m_size[d] = 0;
         else     model_step(d);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      s_of    = '{2, 3, 3, 1};
      skid_of = '{0, 0, 1, 1};
      fcd_of  = '{1, 1, 0, 1};
      for (int d = 0; d < 4; d++) m_size[d] = 0;
      rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; freeze = 1'b0;

      // Reset state
      #2 rst = 1'b1;
      repeat (2) cycle();
      for (int d = 0; d < 4; d++) begin
         check($sformatf("dut%0d reset out_data", d), out_data_w[d], 32'h0);
         check($sformatf("dut%0d reset in_ready", d), 32'(in_ready_w[d]), 32'h1);
      end
      rst = 1'b0;

      // Streaming at full rate
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_data = 32'h11; cycle();
      in_data = 32'h22; cycle();
      in_data = 32'h33; cycle();
      in_valid = 1'b0;
      repeat (5) cycle();

      // Fill against a stalled consumer, then drain
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 32'hB0 + 32'(i);
         cycle();
      end
      in_valid = 1'b0;
      cycle();
      check("dut1 full count", 32'(get_count(1)), 32'd3);
      check("dut1 full in_ready", 32'(in_ready_w[1]), 32'd0);
      check("dut2 full count", 32'(get_count(2)), 32'd4);
      check("dut2 full in_ready", 32'(in_ready_w[2]), 32'd0);
      out_ready = 1'b1;
      repeat (8) cycle();

      // Flush with a word offered in the same cycle
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 32'hC1; cycle();
      in_data = 32'hC2; cycle();
      in_valid = 1'b0;
      cycle();
      flush = 1'b1; in_valid = 1'b1; in_data = 32'hC3;
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      for (int d = 0; d < 4; d++) begin
         check($sformatf("dut%0d flush count", d), 32'(get_count(d)), 32'd0);
         if (fcd_of[d] != 0) check($sformatf("dut%0d flush out_data", d), out_data_w[d], 32'h0);
      end
      out_ready = 1'b1;
      repeat (4) cycle();

      // Multi-cycle flush keeps the chain empty
      flush = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 32'hF1 + 32'(i);
         cycle();
      end
      flush = 1'b0; in_valid = 1'b0;
      cycle();

      // Freeze with a word waiting at the output
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hD1; cycle();
      in_valid = 1'b0;
      repeat (3) cycle();
      freeze = 1'b1; out_ready = 1'b1;
      repeat (3) cycle();
      freeze = 1'b0;
      repeat (4) cycle();

      // Flush takes priority over freeze
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hF0; cycle();
      in_valid = 1'b0;
      freeze = 1'b1; flush = 1'b1; cycle();
      freeze = 1'b0; flush = 1'b0;
      for (int d = 0; d < 4; d++) begin
         check($sformatf("dut%0d flush+freeze count", d), 32'(get_count(d)), 32'd0);
      end

      // Random traffic
      repeat (300) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 29) == 0);
         freeze    = ($urandom_range(0, 9) == 0);
         cycle();
      end
      flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (6) cycle();

      // Asynchronous reset between edges with two words held
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 32'hE1; cycle();
      in_data = 32'hE2; cycle();
      in_valid = 1'b0;
      cycle();
      check("dut0 pre-reset count", 32'(get_count(0)), 32'd2);
      #2 rst = 1'b1;
      #1;
      for (int d = 0; d < 4; d++) begin
         check($sformatf("dut%0d async count", d), 32'(get_count(d)), 32'd0);
         check($sformatf("dut%0d async out_valid", d), 32'(out_valid_w[d]), 32'd0);
         check($sformatf("dut%0d async out_data", d), out_data_w[d], 32'h0);
         m_size[d] = 0;
      end
      cycle();
      rst = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'hE5; cycle();
      in_valid = 1'b0;
      repeat (5) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
